// File: rtl/ct_f_spsram_init_wrap.sv
// Single-port SRAM wrapper that sweeps INIT_VALUE into every word after reset
// and accepts user accesses only once the sweep has finished.
module ct_f_spsram_init_wrap #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 84,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Q_VLD,
    output logic                  INIT_DONE
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic                    init_we;
    logic                    user_we, user_rd;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [STAGES-1:0]       vld_pipe;

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_we   = 1'b0;
        case (state)
            ST_INIT: begin
                init_we = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (&cnt) state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    assign INIT_DONE = (state == ST_IDLE);
    assign user_we   = INIT_DONE && !CEN && !GWEN;
    assign user_rd   = INIT_DONE && !CEN &&  GWEN;

    // Array is never reset directly; the sweep is the only way it gets cleared.
    always_ff @(posedge CLK) begin
        if (RST_B) begin
            if (init_we)
                mem[cnt] <= INIT_VALUE;
            else if (user_we)
                mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            vld_pipe <= '0;
            rd_q     <= '0;
        end else begin
            vld_pipe[0] <= user_rd;
            for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (user_rd) rd_q <= mem[A];
        end
    end

    // Output register only advances on a valid beat so Q holds between reads.
    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] q_r;
        always_ff @(posedge CLK) begin
            if (!RST_B)           q_r <= '0;
            else if (vld_pipe[0]) q_r <= rd_q;
        end
        assign Q = q_r;
    end else begin : g_noreg
        assign Q = rd_q;
    end

    assign Q_VLD = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
// Randomized and directed bench: two instances (latency 1 / INIT 00, latency 2 / INIT 3C)
// share inputs and are compared every cycle against a cycle-count based memory model.
module tb_ct_f_spsram_init_wrap;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_b, cen, gwen;
    logic [AW-1:0] a;
    logic [DW-1:0] wen, d;
    logic [DW-1:0] q0, q1;
    logic          v0, v1, dn0, dn1;

    always #5 clk = ~clk;

    ct_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_VALUE(8'h00)) dut0 (
        .CLK(clk), .RST_B(rst_b), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q0), .Q_VLD(v0), .INIT_DONE(dn0));

    ct_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_VALUE(8'h3C)) dut1 (
        .CLK(clk), .RST_B(rst_b), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q1), .Q_VLD(v1), .INIT_DONE(dn1));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents plus cycles elapsed since reset release.
    logic [DW-1:0] m0 [DEPTH];
    logic [DW-1:0] m1 [DEPTH];
    int            since_rel = 0;
    bit            armed = 0;
    logic [DW-1:0] e_q0, e_q1, p_d;
    logic          e_v0, e_v1, p_rd;

    task automatic cyc();
        bit            rd;
        logic [DW-1:0] r0, r1;
        @(posedge clk);
        if (!rst_b) begin
            since_rel = 0;
            armed = 1;
            e_q0 = '0; e_q1 = '0; e_v0 = 0; e_v1 = 0; p_rd = 0; p_d = '0;
        end else begin
            rd = 0; r0 = '0; r1 = '0;
            if (since_rel >= DEPTH && !cen) begin
                if (gwen) begin
                    rd = 1; r0 = m0[a]; r1 = m1[a];
                end else begin
                    m0[a] = (m0[a] & wen) | (d & ~wen);
                    m1[a] = (m1[a] & wen) | (d & ~wen);
                end
            end
            e_v0 = rd;
            if (rd) e_q0 = r0;
            e_v1 = p_rd;
            if (p_rd) e_q1 = p_d;
            p_rd = rd; p_d = r1;
            if (since_rel < DEPTH) begin
                since_rel++;
                if (since_rel == DEPTH)
                    for (int i = 0; i < DEPTH; i++) begin m0[i] = 8'h00; m1[i] = 8'h3C; end
            end
        end
        #1;
        if (armed) begin
            chk("q0", q0, e_q0);
            chk("q_vld0", v0, e_v0);
            chk("init_done0", dn0, since_rel >= DEPTH);
            chk("q1", q1, e_q1);
            chk("q_vld1", v1, e_v1);
            chk("init_done1", dn1, since_rel >= DEPTH);
        end
    endtask

    task automatic wr(input logic [AW-1:0] ad, input logic [DW-1:0] dd, input logic [DW-1:0] m);
        cen = 0; gwen = 0; a = ad; d = dd; wen = m; cyc();
    endtask

    task automatic rd(input logic [AW-1:0] ad);
        cen = 0; gwen = 1; a = ad; d = 8'h5A; wen = 8'h00; cyc();
    endtask

    task automatic idle();
        cen = 1; gwen = 0; a = 4'($urandom); d = 8'($urandom); wen = 8'h00; cyc();
    endtask

    initial begin
        rst_b = 0; cen = 1; gwen = 1; a = '0; wen = '1; d = '0;
        cyc(); cyc();
        chk("rst_q0", q0, 8'h00);
        chk("rst_q1", q1, 8'h00);

        // Sweep with a write request held throughout; it must be ignored.
        rst_b = 1; cen = 0; gwen = 0; d = 8'hFF; wen = 8'h00;
        repeat (DEPTH - 1) cyc();
        chk("done_15", dn0, 1'b0);
        cyc();
        chk("done_16", dn0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            chk("sweep_rd", q0, 8'h00);
        end
        idle(); idle();

        wr(3, 8'hA5, 8'h00);
        rd(3);
        chk("lat1_vld", v0, 1'b1);
        chk("lat1_q", q0, 8'hA5);
        chk("lat2_early", v1, 1'b0);
        idle();
        chk("lat2_vld", v1, 1'b1);
        chk("lat2_q", q1, 8'hA5);
        chk("lat1_hold_vld", v0, 1'b0);

        wr(5, 8'hFF, 8'h00);
        wr(5, 8'h00, 8'hF0);
        rd(5);
        chk("mask_q", q0, 8'hF0);
        idle();

        wr(0, 8'h10, 8'h00); wr(1, 8'h11, 8'h00); wr(2, 8'h12, 8'h00);
        rd(0); rd(1); rd(2);
        idle(); idle(); idle();
        chk("hold_q0", q0, 8'h12);
        chk("hold_q1", q1, 8'h12);

        // In-flight read discarded by reset, then re-sweep restores INIT_VALUE.
        wr(7, 8'h01, 8'h00);
        rd(7);
        rst_b = 0; cen = 0; gwen = 1; a = 7;
        cyc();
        chk("rst_flight_vld1", v1, 1'b0);
        chk("rst_flight_q1", q1, 8'h00);
        chk("rst_flight_done", dn1, 1'b0);
        rst_b = 1;
        repeat (DEPTH) idle();
        rd(7); idle();
        chk("resweep_q1", q1, 8'h3C);

        // Mid-sweep reset.
        rst_b = 0; cyc(); rst_b = 1;
        repeat (5) idle();
        rst_b = 0; cyc(); rst_b = 1;
        repeat (DEPTH) idle();

        for (int n = 0; n < 3000; n++) begin
            rst_b = ($urandom_range(0, 299) != 0);
            cen   = ($urandom_range(0, 3) == 0);
            gwen  = 1'($urandom);
            a     = 4'($urandom);
            d     = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       wen = 8'h00;
                1:       wen = 8'hFF;
                default: wen = 8'($urandom);
            endcase
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
